// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline register.
// The entry struct is sized for the default datapath configuration.
package ex_mem_pkg;
   localparam int DATA_W_DEF = 64;
   localparam int REG_AW_DEF = 5;
   localparam int CTRL_W     = 4;

   // Ctrl bus bit positions: {RegWrite, MemToReg, MemRead, MemWrite}
   localparam int CTRL_REGWRITE = 3;
   localparam int CTRL_MEMTOREG = 2;
   localparam int CTRL_MEMREAD  = 1;
   localparam int CTRL_MEMWRITE = 0;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] result;
      logic [DATA_W_DEF-1:0] store_data;
      logic [DATA_W_DEF-1:0] target;
      logic [REG_AW_DEF-1:0] rd;
      logic [CTRL_W-1:0]     ctrl;
      logic                  pcsrc;
   } ex_mem_entry_t;
endpackage

// File: rtl/ex_mem_skid_buf.sv
// Two-entry (main + skid) buffer. in_ready depends only on the registered
// skid occupancy, gated by reset and flush, so OutReady never reaches InReady.
module ex_mem_skid_buf
   import ex_mem_pkg::*;
#(
   parameter type entry_t = ex_mem_entry_t
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   flush,
   input  logic   in_valid,
   output logic   in_ready,
   input  entry_t in_entry,
   output logic   out_valid,
   input  logic   out_ready,
   output entry_t out_entry
);
   logic   main_vld, skid_vld, in_fire;
   entry_t main_q, skid_q;

   assign in_ready  = !rst && !flush && !skid_vld;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = main_vld;
   assign out_entry = main_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         main_q   <= '0;
         skid_q   <= '0;
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
      end else if (!main_vld || out_ready) begin
         // main slot frees up: the skid entry is older than anything incoming
         if (skid_vld) begin
            main_vld <= 1'b1;
            main_q   <= skid_q;
            skid_vld <= 1'b0;
         end else begin
            main_vld <= in_fire;
            if (in_fire) main_q <= in_entry;
         end
      end else if (in_fire) begin
         skid_vld <= 1'b1;
         skid_q   <= in_entry;
      end
   end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake and flush.
// Define EX_MEM_SKID_EN for the two-entry skid buffer with registered InReady.
module ex_mem_stage
   import ex_mem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
)(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              InValid,
   output logic              InReady,
   input  logic [DATA_W-1:0] ALUResult,
   input  logic              Zero,
   input  logic [DATA_W-1:0] StoreData,
   input  logic [REG_AW-1:0] Rd,
   input  logic [CTRL_W-1:0] Ctrl,
   input  logic              Branch,
   input  logic              Uncond,
   input  logic [DATA_W-1:0] BranchTarget,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [DATA_W-1:0] OutALUResult,
   output logic [DATA_W-1:0] OutStoreData,
   output logic [DATA_W-1:0] OutBranchTarget,
   output logic [REG_AW-1:0] OutRd,
   output logic [CTRL_W-1:0] OutCtrl,
   output logic              PCSrc
);
   // Same field layout as ex_mem_entry_t, sized by this instance's parameters
   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [DATA_W-1:0] store_data;
      logic [DATA_W-1:0] target;
      logic [REG_AW-1:0] rd;
      logic [CTRL_W-1:0] ctrl;
      logic              pcsrc;
   } entry_t;

   entry_t in_ent, out_ent;
   logic   out_vld;

   always_comb begin
      in_ent            = '0;
      in_ent.result     = ALUResult;
      in_ent.store_data = StoreData;
      in_ent.target     = BranchTarget;
      in_ent.rd         = Rd;
      in_ent.ctrl       = Ctrl;
      in_ent.pcsrc      = Uncond | (Branch & Zero);
   end

`ifdef EX_MEM_SKID_EN
   ex_mem_skid_buf #(.entry_t(entry_t)) u_skid (
      .clk       (Clk),
      .rst       (Rst),
      .flush     (Flush),
      .in_valid  (InValid),
      .in_ready  (InReady),
      .in_entry  (in_ent),
      .out_valid (out_vld),
      .out_ready (OutReady),
      .out_entry (out_ent)
   );
`else
   entry_t ent_q;
   logic   vld_q;

   assign InReady = !Rst && !Flush && (!vld_q || OutReady);
   assign out_vld = vld_q;
   assign out_ent = ent_q;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         vld_q <= 1'b0;
         ent_q <= '0;
      end else if (Flush) begin
         vld_q <= 1'b0;
      end else if (InReady) begin
         // slot is empty or draining this edge
         vld_q <= InValid;
         if (InValid) ent_q <= in_ent;
      end
   end
`endif

   assign OutValid        = out_vld;
   assign OutALUResult    = out_vld ? out_ent.result     : '0;
   assign OutStoreData    = out_vld ? out_ent.store_data : '0;
   assign OutBranchTarget = out_vld ? out_ent.target     : '0;
   assign OutRd           = out_vld ? out_ent.rd         : '0;
   assign OutCtrl         = out_vld ? out_ent.ctrl       : '0;
   assign PCSrc           = out_vld & out_ent.pcsrc;
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: accepted entries are queued with their
// expected outputs, a negedge monitor compares and tracks occupancy.
module tb_ex_mem_stage;
   logic        Clk = 1'b0;
   logic        Rst, InValid, InReady, Zero, Branch, Uncond, Flush;
   logic        OutValid, OutReady, PCSrc;
   logic [63:0] ALUResult, StoreData, BranchTarget;
   logic [63:0] OutALUResult, OutStoreData, OutBranchTarget;
   logic [4:0]  Rd, OutRd;
   logic [3:0]  Ctrl, OutCtrl;

   ex_mem_stage dut (
      .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
      .ALUResult(ALUResult), .Zero(Zero), .StoreData(StoreData), .Rd(Rd),
      .Ctrl(Ctrl), .Branch(Branch), .Uncond(Uncond), .BranchTarget(BranchTarget),
      .Flush(Flush), .OutValid(OutValid), .OutReady(OutReady),
      .OutALUResult(OutALUResult), .OutStoreData(OutStoreData),
      .OutBranchTarget(OutBranchTarget), .OutRd(OutRd), .OutCtrl(OutCtrl),
      .PCSrc(PCSrc)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [63:0] res, sd, tgt;
      logic [4:0]  rd;
      logic [3:0]  ctrl;
      logic        pcsrc;
   } exp_t;

   exp_t q[$];
   int   checks = 0, failures = 0, pops = 0;

`ifdef EX_MEM_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Occupancy-based reference: an entry leaves when presented and OutReady,
   // enters when offered and accepted; flush or reset empties the stage.
   always @(negedge Clk) begin
      if (Rst) begin
         chk("rst_outvalid", {63'd0, OutValid}, 64'd0);
         chk("rst_inready", {63'd0, InReady}, 64'd0);
         chk("rst_pcsrc", {63'd0, PCSrc}, 64'd0);
         chk("rst_data", OutALUResult | OutStoreData | OutBranchTarget, 64'd0);
         q.delete();
      end else begin
         automatic logic exp_rdy;
         chk("outvalid", {63'd0, OutValid}, {63'd0, q.size() > 0});
         if (DEPTH == 2) exp_rdy = !Flush && (q.size() < 2);
         else            exp_rdy = !Flush && (q.size() == 0 || OutReady);
         chk("inready", {63'd0, InReady}, {63'd0, exp_rdy});
         if (OutValid && q.size() > 0) begin
            chk("out_result", OutALUResult, q[0].res);
            chk("out_store", OutStoreData, q[0].sd);
            chk("out_target", OutBranchTarget, q[0].tgt);
            chk("out_rd_ctrl_pcsrc", {54'd0, OutRd, OutCtrl, PCSrc},
                {54'd0, q[0].rd, q[0].ctrl, q[0].pcsrc});
         end else if (!OutValid) begin
            chk("idle_zero", OutALUResult | OutStoreData | OutBranchTarget |
                {54'd0, OutRd, OutCtrl, PCSrc}, 64'd0);
         end
         if (Flush) q.delete();
         else begin
            if (OutValid && OutReady && q.size() > 0) begin
               void'(q.pop_front());
               pops++;
            end
            if (InValid && InReady) begin
               automatic exp_t e;
               e.res = ALUResult; e.sd = StoreData; e.tgt = BranchTarget;
               e.rd = Rd; e.ctrl = Ctrl;
               e.pcsrc = Uncond || (Branch && Zero);
               q.push_back(e);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge Clk); #2; end
   endtask

   task automatic set_in(input logic v, input logic [63:0] res, input logic [4:0] rd,
                         input logic br, input logic un, input logic z, input logic [63:0] tgt);
      InValid = v; ALUResult = res; Rd = rd; Branch = br; Uncond = un; Zero = z;
      BranchTarget = tgt; StoreData = {$urandom, $urandom}; Ctrl = 4'($urandom);
   endtask

   task automatic set_rand(input logic v);
      set_in(v, {$urandom, $urandom}, 5'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), {$urandom, $urandom});
   endtask

   // Offer one entry and hold it until accepted (bounded)
   task automatic send_hs(input logic [63:0] res);
      int  n = 0;
      logic fired;
      set_in(1'b1, res, 5'd1, 1'b0, 1'b0, 1'b0, 64'h0);
      do begin
         @(negedge Clk); fired = InReady;
         @(posedge Clk); #2; n++;
      end while (!fired && n < 50);
      checks++;
      if (!fired) begin
         failures++;
         $display("FAIL send_timeout actual=not_accepted required=accepted res=%0h", res);
      end
      InValid = 1'b0;
   endtask

   initial begin
      int p0;
      Rst = 1'b1; Flush = 1'b0; OutReady = 1'b0;
      set_in(1'b0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 64'h0);
      cyc(3);
      Rst = 1'b0;
      #1 chk("ready_after_rst", {63'd0, InReady}, 64'd1);

      // Basic latency-1 capture
      OutReady = 1'b1;
      set_in(1'b1, 64'h10, 5'd3, 1'b0, 1'b0, 1'b0, 64'h0);
      cyc(1);
      InValid = 1'b0;
      chk("lat1_valid", {63'd0, OutValid}, 64'd1);
      chk("lat1_result", OutALUResult, 64'h10);
      chk("lat1_rd", {59'd0, OutRd}, 64'd3);
      cyc(2);

      // Branch resolution
      set_in(1'b1, 64'h1, 5'd1, 1'b1, 1'b0, 1'b1, 64'h400);
      cyc(1);
      chk("cbz_taken", {63'd0, PCSrc}, 64'd1);
      chk("cbz_target", OutBranchTarget, 64'h400);
      set_in(1'b1, 64'h2, 5'd2, 1'b1, 1'b0, 1'b0, 64'h404);
      cyc(1);
      chk("cbz_not_taken", {63'd0, PCSrc}, 64'd0);
      set_in(1'b1, 64'h3, 5'd3, 1'b0, 1'b1, 1'b0, 64'h408);
      cyc(1);
      chk("uncond", {63'd0, PCSrc}, 64'd1);
      InValid = 1'b0;
      cyc(3);

      // Backpressure: A held, B buffered or waiting
      OutReady = 1'b0;
      fork
         begin send_hs(64'h1); send_hs(64'h2); end
         begin
            cyc(3);
            chk("bp_hold_a", OutALUResult, 64'h1);
            chk("bp_inready", {63'd0, InReady}, 64'd0);
            OutReady = 1'b1;
         end
      join
      cyc(4);

      // Flush with a full stage and a simultaneous offer
      OutReady = 1'b0;
      send_hs(64'hA1);
      if (DEPTH == 2) send_hs(64'hA2);
      set_in(1'b1, 64'hDEAD, 5'd7, 1'b0, 1'b0, 1'b0, 64'h0);
      Flush = 1'b1;
      cyc(1);
      Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      chk("flush_empty", {63'd0, OutValid}, 64'd0);
      cyc(3);

      // Reset pulse mid-stream
      set_in(1'b1, 64'h55, 5'd5, 1'b0, 1'b1, 1'b0, 64'h800);
      cyc(2);
      chk("pre_rst_valid", {63'd0, OutValid}, 64'd1);
      Rst = 1'b1;
      #1;
      chk("rst_async_valid", {63'd0, OutValid}, 64'd0);
      chk("rst_async_pcsrc", {63'd0, PCSrc}, 64'd0);
      InValid = 1'b0;
      @(posedge Clk); #2;
      Rst = 1'b0;
      #1 chk("ready_after_pulse", {63'd0, InReady}, 64'd1);
      cyc(2);

      // Back-to-back stream of 100
      OutReady = 1'b1;
      p0 = pops;
      for (int i = 0; i < 100; i++) begin
         set_rand(1'b1);
         cyc(1);
      end
      InValid = 1'b0;
      cyc(1);
      chk("stream_throughput", 64'(pops - p0), 64'd100);
      cyc(3);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         set_rand(($urandom % 4) != 0);
         OutReady = ($urandom % 3) != 0;
         Flush = ($urandom % 40) == 0;
         cyc(1);
      end
      InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
      cyc(5);
      chk("drained", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, datapath width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_AW, default 5, destination register address width.
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port InValid  input  1  upstream (ALU/EX) entry valid.
REQ-006 SHALL have port InReady  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port ALUResult  input  DATA_W  ALU BusW value.
REQ-008 SHALL have port Zero  input  1  ALU zero flag.
REQ-009 SHALL have port StoreData  input  DATA_W  register data for stores.
REQ-010 SHALL have port Rd  input  REG_AW  destination register.
REQ-011 SHALL have port Ctrl  input  4  {RegWrite, MemToReg, MemRead, MemWrite}.
REQ-012 SHALL have port Branch, Uncond  input  1 each  conditional (CBZ) / unconditional branch.
REQ-013 SHALL have port BranchTarget  input  DATA_W  computed branch address.
REQ-014 SHALL have port Flush  input  1  discard all held entries.
REQ-015 SHALL have ports OutValid output 1; OutReady input 1; OutALUResult, OutStoreData, OutBranchTarget output DATA_W; OutRd output REG_AW; OutCtrl output 4; PCSrc output 1 -- downstream (MEM) side.

Function
REQ-016 SHALL transfer an entry in when InValid & InReady, and out when OutValid & OutReady, both on the rising edge.
REQ-017 SHALL present a captured entry on the outputs one cycle after capture when the stage was empty (latency 1).
REQ-018 SHALL compute PCSrc = Uncond | (Branch & Zero) at capture and register it with the entry.
REQ-019 SHALL hold all Out* signals stable while OutValid & !OutReady.
REQ-020 SHALL preserve entry order; no entry dropped or duplicated except by Flush.
REQ-021 SHALL on Flush invalidate every held entry next edge; Flush has priority over a simultaneous capture (incoming entry dropped) and a simultaneous output transfer.
REQ-022 SHALL drive InReady low during the cycle Flush is asserted.
REQ-023 SHALL, when full and OutReady & InValid coincide, emit the oldest entry and accept the new one in the same edge (full throughput).
REQ-024 SHALL drive Out* data to zero whenever OutValid is low.

Reset
REQ-025 SHALL, while Rst is high, asynchronously clear all entries: OutValid=0, PCSrc=0, all Out* data=0, InReady=0.
REQ-026 SHALL raise InReady in the first cycle after Rst deasserts.
REQ-027 SHALL, if Rst asserts mid-transfer, discard the in-flight entry without partial update.

Configuration
REQ-028 SHALL use macro EX_MEM_SKID_EN.
REQ-029 SHALL with EX_MEM_SKID_EN defined hold up to 2 entries (main + skid); InReady is registered, equal to "skid entry empty".
REQ-030 SHALL without EX_MEM_SKID_EN hold 1 entry; InReady = !OutValid | OutReady (combinational path from OutReady).

Structure
REQ-031 SHALL place in shared package ex_mem_pkg: Ctrl bit-position constants, DATA_W/REG_AW defaults, entry struct {result, store data, target, rd, ctrl, pcsrc}.
REQ-032 SHALL implement the two-entry buffer as sub-module ex_mem_skid_buf, instantiated only under EX_MEM_SKID_EN.

Verification
REQ-033 SHALL cover: reset release, InValid=1, ALUResult=0x10, Rd=3, OutReady=1 -> next cycle OutValid=1, OutALUResult=0x10, OutRd=3.
REQ-034 SHALL cover: Branch=1, Zero=1, BranchTarget=0x400 -> PCSrc=1, OutBranchTarget=0x400; Branch=1, Zero=0 -> PCSrc=0; Uncond=1, Zero=0 -> PCSrc=1.
REQ-035 SHALL cover: OutReady=0 for 3 cycles with entries A=0x1, B=0x2 offered -> outputs hold A; skid build holds B with InReady=0; non-skid has InReady=0 and B waits; on OutReady=1 -> A then B.
REQ-036 SHALL cover: Flush=1 with InValid=1 while 2 entries held -> next cycle OutValid=0; the incoming entry never appears.
REQ-037 SHALL cover: Rst pulsed mid-stream with OutValid=1 -> OutValid and PCSrc 0 immediately (before the next edge), InReady=1 first cycle after release.
REQ-038 SHALL cover: back-to-back stream of 100 entries, OutReady=1 -> one output per cycle, order preserved in both builds.
